// File: rtl/bus_slave_mux.sv
// Routes one master access to one of eight slaves and returns the selected slave's read data.
// Optional macro BUS_TIMEOUT_EN adds a WAIT-cycle timeout that aborts the access with m_err.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef CS_ENABLE
`define CS_ENABLE 1'b1
`endif

module bus_slave_mux #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   m_as,
  input  logic                   m_rw,
  input  logic                   s0_cs,
  input  logic                   s1_cs,
  input  logic                   s2_cs,
  input  logic                   s3_cs,
  input  logic                   s4_cs,
  input  logic                   s5_cs,
  input  logic                   s6_cs,
  input  logic                   s7_cs,
  input  logic                   s0_rdy,
  input  logic                   s1_rdy,
  input  logic                   s2_rdy,
  input  logic                   s3_rdy,
  input  logic                   s4_rdy,
  input  logic                   s5_rdy,
  input  logic                   s6_rdy,
  input  logic                   s7_rdy,
  input  logic [`DATA_WIDTH-1:0] s0_rd_data,
  input  logic [`DATA_WIDTH-1:0] s1_rd_data,
  input  logic [`DATA_WIDTH-1:0] s2_rd_data,
  input  logic [`DATA_WIDTH-1:0] s3_rd_data,
  input  logic [`DATA_WIDTH-1:0] s4_rd_data,
  input  logic [`DATA_WIDTH-1:0] s5_rd_data,
  input  logic [`DATA_WIDTH-1:0] s6_rd_data,
  input  logic [`DATA_WIDTH-1:0] s7_rd_data,
  output logic [`DATA_WIDTH-1:0] m_rd_data,
  output logic                   m_rdy,
  output logic                   m_err,
  output logic                   m_busy
);

  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 1023) begin : gen_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..1023");
  end

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                   state_q, state_d;
  logic [2:0]               idx_q, idx_d;
  logic                     rw_q, rw_d;
  logic [`DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic [7:0]               cs_vec;
  logic [7:0]               rdy_vec;
  logic [`DATA_WIDTH-1:0]   rd_data_arr [8];
  logic [2:0]               sel_idx;

`ifdef BUS_TIMEOUT_EN
  localparam logic [9:0] Limit = 10'(TIMEOUT_CYCLES);
  logic [9:0] cnt_q, cnt_d;
  logic       err_q, err_d;
`endif

  assign cs_vec  = {s7_cs, s6_cs, s5_cs, s4_cs, s3_cs, s2_cs, s1_cs, s0_cs};
  assign rdy_vec = {s7_rdy, s6_rdy, s5_rdy, s4_rdy, s3_rdy, s2_rdy, s1_rdy, s0_rdy};

  assign rd_data_arr[0] = s0_rd_data;
  assign rd_data_arr[1] = s1_rd_data;
  assign rd_data_arr[2] = s2_rd_data;
  assign rd_data_arr[3] = s3_rd_data;
  assign rd_data_arr[4] = s4_rd_data;
  assign rd_data_arr[5] = s5_rd_data;
  assign rd_data_arr[6] = s6_rd_data;
  assign rd_data_arr[7] = s7_rd_data;

  // Scan downwards so the lowest-numbered asserted select wins; none asserted falls to 7.
  always_comb begin
    sel_idx = 3'd7;
    for (int i = 7; i >= 0; i--) begin
      if (cs_vec[i] == `CS_ENABLE) sel_idx = 3'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rw_d      = rw_q;
    rd_data_d = rd_data_q;
`ifdef BUS_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (m_as) begin
          idx_d   = sel_idx;
          rw_d    = m_rw;
`ifdef BUS_TIMEOUT_EN
          cnt_d   = '0;
`endif
          state_d = StWait;
        end
      end
      StWait: begin
        if (rdy_vec[idx_q]) begin
          rd_data_d = rw_q ? '0 : rd_data_arr[idx_q];
`ifdef BUS_TIMEOUT_EN
          err_d     = 1'b0;
`endif
          state_d   = StResp;
        end
`ifdef BUS_TIMEOUT_EN
        // rdy is checked first so a ready arriving on the limit cycle still succeeds.
        else if (cnt_q == Limit - 10'd1) begin
          cnt_d     = cnt_q + 10'd1;
          rd_data_d = '0;
          err_d     = 1'b1;
          state_d   = StResp;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
`endif
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      rw_q      <= 1'b0;
      rd_data_q <= '0;
`ifdef BUS_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rw_q      <= rw_d;
      rd_data_q <= rd_data_d;
`ifdef BUS_TIMEOUT_EN
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  assign m_rd_data = rd_data_q;
  assign m_rdy     = (state_q == StResp);
  assign m_busy    = (state_q != StIdle);
`ifdef BUS_TIMEOUT_EN
  assign m_err     = m_rdy & err_q;
`else
  assign m_err     = 1'b0;
`endif

endmodule

// File: doc/bus_slave_mux.md
BUS_SLAVE_MUX -- requirements
Module: bus_slave_mux

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the number of WAIT cycles without slave ready before the access aborts (range 1..1023).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port m_as, input, 1, master address strobe; a 1-cycle pulse starts an access.
REQ-005 SHALL have port m_rw, input, 1, access direction (1 = write, 0 = read), sampled with m_as.
REQ-006 SHALL have ports s0_cs..s7_cs, input, 1 each, chip selects from the address decoder; asserted at the `CS_ENABLE level.
REQ-007 SHALL have ports s0_rdy..s7_rdy, input, 1 each, slave-ready strobes, active-high.
REQ-008 SHALL have ports s0_rd_data..s7_rd_data, input, `DATA_WIDTH (32) each, slave read data, valid while the matching sN_rdy is high.
REQ-009 SHALL have port m_rd_data, output, `DATA_WIDTH, registered read data returned to the master.
REQ-010 SHALL have port m_rdy, output, 1, one-cycle completion strobe to the master.
REQ-011 SHALL have port m_err, output, 1, abort flag, valid only while m_rdy is high.
REQ-012 SHALL have port m_busy, output, 1, high whenever the state is not IDLE.

Function
REQ-013 SHALL implement three states: IDLE, WAIT, RESP.
REQ-014 In IDLE with m_as=1, SHALL latch a 3-bit slave index from the chip selects plus m_rw, clear the timeout counter, and move to WAIT.
REQ-015 The index SHALL be that of the lowest-numbered asserted chip select; if none is asserted, the index SHALL be 7.
REQ-016 In IDLE, sN_rdy inputs SHALL be ignored, including any rdy asserted in the same cycle as m_as.
REQ-017 In WAIT, sN_rdy SHALL be sampled only for the latched index; rdy from every other slave SHALL be ignored.
REQ-018 In WAIT with the selected rdy=1, SHALL register the selected sN_rd_data into m_rd_data (0 if the latched m_rw=1), clear m_err, and move to RESP.
REQ-019 In RESP, m_rdy SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE; latency from sampled slave rdy to m_rdy is 1 cycle.
REQ-020 m_rd_data SHALL hold its value after RESP until the next completion.
REQ-021 m_as asserted while m_busy=1 SHALL be ignored; there is no queueing.
REQ-022 A back-to-back access SHALL be accepted from the IDLE cycle that follows RESP; minimum access period is 3 cycles.

Reset
REQ-023 While reset=1, regardless of the clock, state SHALL be IDLE, m_rd_data SHALL be 0, m_rdy, m_err and m_busy SHALL be 0, and the index and counter SHALL be 0.
REQ-024 Reset asserted mid-access SHALL abandon the access with no m_rdy pulse; slave rdy arriving after reset release SHALL be ignored.

Configuration
REQ-025 With macro BUS_TIMEOUT_EN defined, a 10-bit counter SHALL increment for each WAIT cycle without the selected rdy.
REQ-026 With BUS_TIMEOUT_EN defined and the counter reaching TIMEOUT_CYCLES, the block SHALL move to RESP with m_err=1 and m_rd_data=0.
REQ-027 With BUS_TIMEOUT_EN defined, if rdy arrives in the same cycle the limit is reached, rdy SHALL win and m_err SHALL be 0.
REQ-028 Without BUS_TIMEOUT_EN, no counter SHALL exist, WAIT SHALL persist until the selected rdy arrives, and m_err SHALL be constant 0.

Verification
REQ-029 Read success: m_as with s3_cs enabled, s3_rdy high 4 cycles later with s3_rd_data=0x12345678 -> m_rdy for 1 cycle, 1 cycle after rdy, with m_rd_data=0x12345678 and m_err=0.
REQ-030 Wrong-slave rdy: s5 selected, s2_rdy pulsed with 0xFFFFFFFF, then s5_rdy with 0x0000AAAA -> a single m_rdy with m_rd_data=0x0000AAAA.
REQ-031 Write: m_rw=1 with s0 selected, s0_rdy with s0_rd_data=0xCAFEF00D -> m_rdy with m_rd_data=0x00000000.
REQ-032 Timeout (BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8): s6 selected, no rdy -> m_rdy with m_err=1 and m_rd_data=0 after 8 WAIT cycles; rdy on the 8th cycle -> m_err=0.
REQ-033 Reset mid-WAIT: reset pulsed while in WAIT, then s1_rdy asserted -> no m_rdy pulse, and m_busy=0 immediately on reset.
REQ-034 Busy/back-to-back: second m_as while busy -> ignored; m_as in the cycle after RESP -> accepted and m_busy=1 on the next cycle.
